// File: rtl/connector_pkg.sv
// Shared connection/switch-box definitions: configuration frame geometry
// helpers and the frame-load FSM state encoding.
package connector_pkg;

   // Frame-load progress: nothing shifted, partially shifted, complete frame.
   typedef enum logic [1:0] {
      CB_EMPTY   = 2'd0,
      CB_LOADING = 2'd1,
      CB_FULL    = 2'd2
   } cb_state_e;

   // Select field width; a single input still needs one select bit.
   function automatic int unsigned sel_width(input int unsigned inputs);
      return (inputs > 1) ? $clog2(inputs) : 1;
   endfunction

   // One output's config field: {en, sel}.
   function automatic int unsigned field_width(input int unsigned inputs);
      return sel_width(inputs) + 1;
   endfunction

   // Beats needed to carry every output field, rounded up to a whole beat.
   function automatic int unsigned frame_beats(input int unsigned inputs,
                                               input int unsigned outputs,
                                               input int unsigned chain_width);
      return (outputs * field_width(inputs) + chain_width - 1) / chain_width;
   endfunction

   // Shadow register length including top pad bits.
   function automatic int unsigned shadow_bits(input int unsigned inputs,
                                               input int unsigned outputs,
                                               input int unsigned chain_width);
      return frame_beats(inputs, outputs, chain_width) * chain_width;
   endfunction

endpackage

// File: rtl/connector_box_frame_cb_out_sel.sv
// cb_out_sel: one routed output. Holds the committed {en, sel} field and
// drives the selected input, or 0 when disabled / sel is out of range.
//   clk, rst_n : clock, async active-low reset (clears to disabled)
//   load       : capture field into the active register
//   field      : {en, sel} from the shadow frame
//   data_in    : candidate inputs
//   data_out   : routed bit (combinational from data_in)
module cb_out_sel
   import connector_pkg::*;
#(
   parameter int unsigned INPUTS = 16,
   parameter int unsigned SEL    = sel_width(INPUTS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [SEL:0]      field,
   input  logic [INPUTS-1:0] data_in,
   output logic              data_out
);

   localparam int unsigned SPAN = 1 << SEL;

   logic           act_en;
   logic [SEL-1:0] act_sel;
   logic [SPAN-1:0] padded;

   // Active selector register, updated only on commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_en  <= 1'b0;
         act_sel <= '0;
      end else if (load) begin
         act_en  <= field[SEL];
         act_sel <= field[SEL-1:0];
      end
   end

   // Zero-extending to the full select span makes out-of-range selects read 0.
   assign padded   = SPAN'(data_in);
   assign data_out = act_en & padded[act_sel];

endmodule

// File: rtl/connector_box_frame.sv
// connector_box_frame: double-buffered connection box. Config beats shift
// into a shadow frame; a commit copies it atomically to per-output selectors.
//   config_clk, config_rst_n : clock, async active-low reset
//   config_in/config_en      : incoming beat and shift strobe
//   config_commit            : shadow -> active (only when a frame is full)
//   config_clear             : zero shadow, restart count, clear error
//   config_out               : beat leaving the shadow, to the next box
//   config_full              : complete frame shifted since last commit/clear
//   config_err               : sticky, commit attempted while not full
//   data_in/data_out         : routed signals
module connector_box_frame
   import connector_pkg::*;
#(
   parameter int unsigned INPUTS      = 16,
   parameter int unsigned OUTPUTS     = 6,
   parameter int unsigned CHAIN_WIDTH = 4
) (
   input  logic                   config_clk,
   input  logic                   config_rst_n,
   input  logic [CHAIN_WIDTH-1:0] config_in,
   input  logic                   config_en,
   input  logic                   config_commit,
   input  logic                   config_clear,
   output logic [CHAIN_WIDTH-1:0] config_out,
   output logic                   config_full,
   output logic                   config_err,
   input  logic [INPUTS-1:0]      data_in,
   output logic [OUTPUTS-1:0]     data_out
);

   localparam int unsigned SEL         = sel_width(INPUTS);
   localparam int unsigned FIELD       = field_width(INPUTS);
   localparam int unsigned FRAME_BEATS = frame_beats(INPUTS, OUTPUTS, CHAIN_WIDTH);
   localparam int unsigned SHADOW_BITS = shadow_bits(INPUTS, OUTPUTS, CHAIN_WIDTH);
   localparam int unsigned CNT_W       = $clog2(FRAME_BEATS + 1);
   localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(FRAME_BEATS);

   cb_state_e              state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [SHADOW_BITS-1:0] shadow, shadow_nxt, shifted;
   logic                   err_nxt;
   logic                   commit;

   // New beat enters at the top so output 0's field is the first data shifted.
   if (SHADOW_BITS > CHAIN_WIDTH) begin : g_shift
      assign shifted = {config_in, shadow[SHADOW_BITS-1:CHAIN_WIDTH]};
   end else begin : g_shift_one
      assign shifted = config_in;
   end

   // State register plus shadow, counter and status flags.
   always_ff @(posedge config_clk or negedge config_rst_n) begin
      if (!config_rst_n) begin
         state       <= CB_EMPTY;
         cnt         <= '0;
         shadow      <= '0;
         config_err  <= 1'b0;
         config_full <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         shadow      <= shadow_nxt;
         config_err  <= err_nxt;
         config_full <= (state_nxt == CB_FULL);
      end
   end

   // Next state; clear overrides shift and commit in the same cycle.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      shadow_nxt = shadow;
      err_nxt    = config_err;
      commit     = 1'b0;
      if (config_clear) begin
         state_nxt  = CB_EMPTY;
         cnt_nxt    = '0;
         shadow_nxt = '0;
         err_nxt    = 1'b0;
      end else begin
         if (config_en) begin
            shadow_nxt = shifted;
         end
         case (state)
            CB_EMPTY, CB_LOADING: begin
               if (config_commit) begin
                  err_nxt = 1'b1;
               end
               if (config_en) begin
                  cnt_nxt   = cnt + CNT_W'(1);
                  state_nxt = (cnt_nxt == BEATS_C) ? CB_FULL : CB_LOADING;
               end
            end
            CB_FULL: begin
               // Commit samples the pre-shift shadow; a concurrent beat starts the next frame.
               if (config_commit) begin
                  commit = 1'b1;
                  if (config_en) begin
                     cnt_nxt   = CNT_W'(1);
                     state_nxt = (cnt_nxt == BEATS_C) ? CB_FULL : CB_LOADING;
                  end else begin
                     cnt_nxt   = '0;
                     state_nxt = CB_EMPTY;
                  end
               end
            end
            default: begin
               state_nxt = CB_EMPTY;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign config_out = shadow[CHAIN_WIDTH-1:0];

   // One active selector per output; pad bits at the top of shadow are never loaded.
   for (genvar k = 0; k < OUTPUTS; k++) begin : g_out
      cb_out_sel #(
         .INPUTS (INPUTS),
         .SEL    (SEL)
      ) u_sel (
         .clk      (config_clk),
         .rst_n    (config_rst_n),
         .load     (commit),
         .field    (shadow[k*FIELD +: FIELD]),
         .data_in  (data_in),
         .data_out (data_out[k])
      );
   end

endmodule

// File: tb/tb_connector_box_frame.sv
// Self-checking bench for connector_box_frame: a directed vector table,
// hand-written corner sequences, and randomized traffic against a beat-queue
// reference model. A second instance with INPUTS=12 covers out-of-range selects.
module tb_connector_box_frame;

   localparam int CW   = 4;
   localparam int NOUT = 6;
   localparam int FB   = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  cfg_in;
   logic        en, commit, clear;
   logic [15:0] din;
   logic [3:0]  cout16, cout12;
   logic        full16, full12, err16, err12;
   logic [5:0]  out16, out12;

   int checks   = 0;
   int failures = 0;

   connector_box_frame u_dut (
      .config_clk    (clk),
      .config_rst_n  (rst_n),
      .config_in     (cfg_in),
      .config_en     (en),
      .config_commit (commit),
      .config_clear  (clear),
      .config_out    (cout16),
      .config_full   (full16),
      .config_err    (err16),
      .data_in       (din),
      .data_out      (out16)
   );

   connector_box_frame #(.INPUTS(12)) u_dut12 (
      .config_clk    (clk),
      .config_rst_n  (rst_n),
      .config_in     (cfg_in),
      .config_en     (en),
      .config_commit (commit),
      .config_clear  (clear),
      .config_out    (cout12),
      .config_full   (full12),
      .config_err    (err12),
      .data_in       (din[11:0]),
      .data_out      (out12)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int unsigned m_q[$];      // shadow as beats, index 0 = oldest (next to leave)
   int          m_cnt;       // beats since last commit/clear, saturating
   bit          m_err;
   int unsigned m_act[NOUT]; // committed {en, sel} per output

   task automatic m_reset();
      m_q.delete();
      for (int j = 0; j < FB; j++) m_q.push_back(0);
      m_cnt = 0;
      m_err = 0;
      for (int k = 0; k < NOUT; k++) m_act[k] = 0;
   endtask

   function automatic int unsigned m_field(input int k);
      longint unsigned v = 0;
      for (int j = 0; j < FB; j++) v = v + (longint'(m_q[j]) << (CW * j));
      return int'((v >> (5 * k)) % 32);
   endfunction

   function automatic logic [5:0] m_route(input logic [15:0] d, input int inputs);
      logic [5:0] r = '0;
      for (int k = 0; k < NOUT; k++) begin
         int sel = int'(m_act[k] % 16);
         if (m_act[k] >= 16 && sel < inputs) r[k] = d[sel];
      end
      return r;
   endfunction

   task automatic m_step(input bit e, input int unsigned i, input bit c, input bit cl);
      if (cl) begin
         for (int j = 0; j < FB; j++) m_q[j] = 0;
         m_cnt = 0;
         m_err = 0;
      end else begin
         if (c && m_cnt == FB) begin
            for (int k = 0; k < NOUT; k++) m_act[k] = m_field(k);
            m_cnt = e ? 1 : 0;
         end else begin
            if (c) m_err = 1;
            if (e && m_cnt < FB) m_cnt++;
         end
         if (e) begin
            void'(m_q.pop_front());
            m_q.push_back(i);
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".cfg_out"},   32'(cout16), m_q[0]);
      chk({tag, ".cfg_out12"}, 32'(cout12), m_q[0]);
      chk({tag, ".full"},      32'(full16), 32'(m_cnt == FB));
      chk({tag, ".full12"},    32'(full12), 32'(m_cnt == FB));
      chk({tag, ".err"},       32'(err16),  32'(m_err));
      chk({tag, ".err12"},     32'(err12),  32'(m_err));
      chk({tag, ".data16"},    32'(out16),  32'(m_route(din, 16)));
      chk({tag, ".data12"},    32'(out12),  32'(m_route(din, 12)));
   endtask

   // One clock with the given inputs, model stepped in lockstep.
   task automatic cyc(input logic e, input logic [3:0] i, input logic c,
                      input logic cl, input logic [15:0] d, input string tag);
      en = e; cfg_in = i; commit = c; clear = cl; din = d;
      @(posedge clk);
      m_step(e, i, c, cl);
      #1;
      check_model(tag);
      en = 1'b0; commit = 1'b0; clear = 1'b0;
   endtask

   task automatic load(input logic [29:0] fr, input logic [15:0] d, input string tag);
      logic [31:0] f32;
      f32 = {2'b00, fr};
      for (int i = 0; i < FB; i++) cyc(1'b1, f32[4*i +: 4], 1'b0, 1'b0, d, tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_reset();
      #1;
      chk("rst.data16", 32'(out16), 0);
      chk("rst.cfg_out", 32'(cout16), 0);
      chk("rst.full", 32'(full16), 0);
      chk("rst.err", 32'(err16), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        en;
      logic [3:0]  cin;
      logic        commit;
      logic        clear;
      logic [15:0] din;
      logic [3:0]  x_out;
      logic        x_full;
      logic        x_err;
      logic [5:0]  x_data;
   } vec_t;

   vec_t tbl[11];

   // Frame A: output k <- {1, k+2}
   localparam logic [29:0] FRAME_A = {5'h17, 5'h16, 5'h15, 5'h14, 5'h13, 5'h12};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; cfg_in = '0; en = 1'b0; commit = 1'b0; clear = 1'b0; din = '0;
      m_reset();
      #3;
      chk("reset.data16", 32'(out16), 0);
      chk("reset.cfg_out", 32'(cout16), 0);
      chk("reset.full", 32'(full16), 0);
      chk("reset.err", 32'(err16), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Load and commit frame A (beats 2,7,2,D,A,6,F,2), then route two patterns.
      tbl[0]  = '{1'b1, 4'h2, 1'b0, 1'b0, 16'h0014, 4'h0, 1'b0, 1'b0, 6'h00};
      tbl[1]  = '{1'b1, 4'h7, 1'b0, 1'b0, 16'h0014, 4'h0, 1'b0, 1'b0, 6'h00};
      tbl[2]  = '{1'b1, 4'h2, 1'b0, 1'b0, 16'h0014, 4'h0, 1'b0, 1'b0, 6'h00};
      tbl[3]  = '{1'b1, 4'hD, 1'b0, 1'b0, 16'h0014, 4'h0, 1'b0, 1'b0, 6'h00};
      tbl[4]  = '{1'b1, 4'hA, 1'b0, 1'b0, 16'h0014, 4'h0, 1'b0, 1'b0, 6'h00};
      tbl[5]  = '{1'b1, 4'h6, 1'b0, 1'b0, 16'h0014, 4'h0, 1'b0, 1'b0, 6'h00};
      tbl[6]  = '{1'b1, 4'hF, 1'b0, 1'b0, 16'h0014, 4'h0, 1'b0, 1'b0, 6'h00};
      tbl[7]  = '{1'b1, 4'h2, 1'b0, 1'b0, 16'h0014, 4'h2, 1'b1, 1'b0, 6'h00};
      tbl[8]  = '{1'b0, 4'h0, 1'b1, 1'b0, 16'h0014, 4'h2, 1'b0, 1'b0, 6'h05};
      tbl[9]  = '{1'b0, 4'h0, 1'b0, 1'b0, 16'hFFFF, 4'h2, 1'b0, 1'b0, 6'h3F};
      tbl[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 16'h0028, 4'h2, 1'b0, 1'b0, 6'h0A};
      for (int i = 0; i < 11; i++) begin
         cyc(tbl[i].en, tbl[i].cin, tbl[i].commit, tbl[i].clear, tbl[i].din, "tbl");
         chk($sformatf("tbl%0d.cfg_out", i), 32'(cout16), 32'(tbl[i].x_out));
         chk($sformatf("tbl%0d.full", i),    32'(full16), 32'(tbl[i].x_full));
         chk($sformatf("tbl%0d.err", i),     32'(err16),  32'(tbl[i].x_err));
         chk($sformatf("tbl%0d.data", i),    32'(out16),  32'(tbl[i].x_data));
      end

      // Early commit after 5 beats: error, no routing change, count kept.
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, 4'h1, 1'b0, 1'b0, 16'hFFFF, "early");
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 16'hFFFF, "early.commit");
      chk("early.err", 32'(err16), 1);
      chk("early.full", 32'(full16), 0);
      chk("early.data", 32'(out16), 0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 4'h1, 1'b0, 1'b0, 16'hFFFF, "early.fill");
      chk("early.full_after_8", 32'(full16), 1);
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 16'hFFFF, "early.clear");
      chk("early.clear_err", 32'(err16), 0);
      chk("early.clear_full", 32'(full16), 0);

      // Chain forwarding: 12 beats, first beat A, second 5.
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, (i % 2 == 0) ? 4'hA : 4'h5, 1'b0, 1'b0, 16'h0, "chain");
         if (i == 7) chk("chain.out_after_8", 32'(cout16), 32'hA);
         if (i == 8) chk("chain.out_after_9", 32'(cout16), 32'h5);
         if (i >= 7) chk("chain.full_hold", 32'(full16), 1);
      end

      // Commit + en in FULL: old frame committed, next frame already 1 beat in.
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 16'h0014, "sim.clear");
      load(FRAME_A, 16'h0014, "sim.loadA");
      cyc(1'b1, 4'h9, 1'b1, 1'b0, 16'h0014, "sim.commit_en");
      chk("sim.commit_en_data", 32'(out16), 32'h05);
      chk("sim.commit_en_full", 32'(full16), 0);
      for (int i = 0; i < 7; i++) begin
         cyc(1'b1, 4'h0, 1'b0, 1'b0, 16'h0014, "sim.next");
         chk($sformatf("sim.next_full%0d", i), 32'(full16), (i == 6) ? 1 : 0);
      end

      // Clear + commit with a full frame pending and err set: nothing commits.
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 16'h0014, "cc.clear");
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 16'h0014, "cc.err");
      chk("cc.err_set", 32'(err16), 1);
      load({6{5'h10}}, 16'h0014, "cc.loadB");
      cyc(1'b0, 4'h0, 1'b1, 1'b1, 16'h0014, "cc.clear_commit");
      chk("cc.data_kept", 32'(out16), 32'h05);
      chk("cc.err_clr", 32'(err16), 0);
      chk("cc.full_clr", 32'(full16), 0);

      // Disabled / out-of-range fields.
      load({5'h0F, 5'h11, 5'h10, 5'h1B, 5'h1F, 5'h03}, 16'h0, "oor.load");
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 16'h8801, "oor.commit");
      chk("oor.data16_a", 32'(out16), 32'h0E);
      chk("oor.data12_a", 32'(out12), 32'h0C);
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 16'h7FFF, "oor.b");
      chk("oor.data16_b", 32'(out16), 32'h1C);
      chk("oor.data12_b", 32'(out12), 32'h1C);

      // Async reset mid-load after 4 beats, then a clean frame.
      for (int i = 0; i < 4; i++) cyc(1'b1, 4'hC, 1'b0, 1'b0, 16'hFFFF, "ar.partial");
      #2;
      do_reset();
      load(FRAME_A, 16'h0014, "ar.load");
      chk("ar.full", 32'(full16), 1);
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 16'h0014, "ar.commit");
      chk("ar.data", 32'(out16), 32'h05);

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         cyc(1'($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 40) == 0),
             16'($urandom), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
